// File: rtl/mp_add_pkg.sv
// Shared definitions for the word-serial multi-precision adder.
package mp_add_pkg;

  // Width of the single shared adder datapath
  localparam int unsigned WORD_W = 16;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Width of the word index counter for a given word count
  function automatic int unsigned idx_w(input int unsigned nwords);
    return (nwords <= 2) ? 1 : $clog2(nwords);
  endfunction

endpackage

// File: rtl/mp_add_seq_if.sv
// Request/result handshake bundle for mp_add_seq.
// op_sub only exists when SUBTRACT_EN is defined.
interface mp_add_seq_if #(
  parameter int unsigned NWORDS = 4
);
  localparam int unsigned OP_W = mp_add_pkg::WORD_W * NWORDS;

  logic            in_valid;
  logic            in_ready;
  logic [OP_W-1:0] op_a;
  logic [OP_W-1:0] op_b;
  logic            cin;
`ifdef SUBTRACT_EN
  logic            op_sub;
`endif
  logic            out_valid;
  logic            out_ready;
  logic [OP_W-1:0] sum;
  logic            cout;
  logic            ovf;

  // Requester / result consumer side
  modport master (
    output in_valid, op_a, op_b, cin,
`ifdef SUBTRACT_EN
    output op_sub,
`endif
    output out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  // Adder block side
  modport slave (
    input  in_valid, op_a, op_b, cin,
`ifdef SUBTRACT_EN
    input  op_sub,
`endif
    input  out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface

// File: rtl/manchester_adder.sv
// Manchester carry-chain adder, W bits, purely combinational.
module manchester_adder #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         Cin,
  output logic [W-1:0] Sum,
  output logic         Cout
);

  logic [W-1:0] gen;
  logic [W-1:0] prop;
  logic [W:0]   chain;

  assign gen  = A & B;
  assign prop = A ^ B;

  // Ripple the carry through the generate/propagate chain
  always_comb begin
    logic [W:0] c;
    c    = '0;
    c[0] = Cin;
    for (int i = 0; i < int'(W); i++) begin
      c[i+1] = gen[i] | (prop[i] & c[i]);
    end
    chain = c;
  end

  assign Sum  = prop ^ chain[W-1:0];
  assign Cout = chain[W];

endmodule

// File: rtl/mp_add_seq.sv
// mp_add_seq: word-serial multi-precision adder, one WORD_W slice per cycle
// through a single shared adder. Optional subtract mode: SUBTRACT_EN.
module mp_add_seq
  import mp_add_pkg::*;
#(
  parameter int unsigned NWORDS = 4
) (
  input  logic         clk,
  input  logic         rst,
  mp_add_seq_if.slave  bus
);

  localparam int unsigned WORD_W = mp_add_pkg::WORD_W;
  localparam int unsigned OP_W   = WORD_W * NWORDS;
  localparam int unsigned IDX_W  = idx_w(NWORDS);

  localparam logic [1:0] ST_IDLE = 2'(IDLE);
  localparam logic [1:0] ST_RUN  = 2'(RUN);
  localparam logic [1:0] ST_DONE = 2'(DONE);

  logic [1:0]        state_q;
  logic [1:0]        state_d;
  logic [IDX_W-1:0]  idx_q;
  logic              carry_q;
  logic [OP_W-1:0]   a_q;
  logic [OP_W-1:0]   b_q;
  logic [OP_W-1:0]   sum_q;
  logic              cout_q;
  logic              ovf_q;
  logic              out_valid_q;
  logic              in_ready_q;

  logic              sub_c;
  logic              last_c;
  logic [WORD_W-1:0] a_word_c;
  logic [WORD_W-1:0] b_word_c;
  logic [WORD_W-1:0] add_sum_c;
  logic              add_cout_c;
  logic              ovf_c;

`ifdef SUBTRACT_EN
  assign sub_c = bus.op_sub;
`else
  assign sub_c = 1'b0;
`endif

  assign last_c = (idx_q == IDX_W'(NWORDS - 1));

  // Select the current word slice of both latched operands
  always_comb begin
    a_word_c = '0;
    b_word_c = '0;
    for (int i = 0; i < int'(NWORDS); i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_word_c = a_q[i*WORD_W +: WORD_W];
        b_word_c = b_q[i*WORD_W +: WORD_W];
      end
    end
  end

  // Single shared datapath; carry between words only via carry_q
  manchester_adder #(
    .W (WORD_W)
  ) u_adder (
    .A    (a_word_c),
    .B    (b_word_c),
    .Cin  (carry_q),
    .Sum  (add_sum_c),
    .Cout (add_cout_c)
  );

  // Signed overflow, meaningful only on the most significant word
  assign ovf_c = (a_word_c[WORD_W-1] == b_word_c[WORD_W-1]) &&
                 (add_sum_c[WORD_W-1] != a_word_c[WORD_W-1]);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.in_valid)  state_d = ST_RUN;
      ST_RUN:  if (last_c)        state_d = ST_DONE;
      ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase
  end

  // Operand latch, per-word accumulation and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid) begin
            a_q        <= bus.op_a;
            b_q        <= sub_c ? ~bus.op_b : bus.op_b;
            carry_q    <= sub_c ? 1'b1 : bus.cin;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
          end
        end
        ST_RUN: begin
          for (int i = 0; i < int'(NWORDS); i++) begin
            if (idx_q == IDX_W'(i)) sum_q[i*WORD_W +: WORD_W] <= add_sum_c;
          end
          carry_q <= add_cout_c;
          if (last_c) begin
            idx_q       <= '0;
            cout_q      <= add_cout_c;
            ovf_q       <= ovf_c;
            out_valid_q <= 1'b1;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_mp_add_seq.sv
// Testbench for mp_add_seq: directed corner cases plus random operands
// checked against a full-width arithmetic reference.
module tb_mp_add_seq;

  localparam int unsigned NW = 4;
  localparam int unsigned W  = 16 * NW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mp_add_seq_if #(.NWORDS(NW)) bus ();

  mp_add_seq #(.NWORDS(NW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int acc_cyc;

  logic [W-1:0] exp_s;
  logic         exp_co;
  logic         exp_ov;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: whole-operand two's-complement arithmetic
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       input logic sub, output logic [W-1:0] s, output logic co,
                       output logic ov);
    logic [W-1:0] be;
    logic         ci;
    logic [W:0]   t;
    be = sub ? ~b : b;
    ci = sub ? 1'b1 : c;
    t  = {1'b0, a} + {1'b0, be} + (W+1)'(ci);
    s  = t[W-1:0];
    co = t[W];
    ov = (a[W-1] == be[W-1]) && (s[W-1] != a[W-1]);
  endtask

  function automatic logic [W-1:0] rand_op();
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < int'(NW); i++) v[i*16 +: 16] = 16'($urandom);
    return v;
  endfunction

  // Wait for in_ready, present one request, record the accepting cycle
  task automatic start(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       input logic sub);
    int t;
    logic s_eff;
    t = 0;
    while (bus.in_ready !== 1'b1 && t < 50) begin
      @(posedge clk); #1; t++;
    end
    chk("ready_before_req", W'(bus.in_ready), W'(1));
`ifdef SUBTRACT_EN
    s_eff = sub;
    bus.op_sub = sub;
`else
    s_eff = 1'b0;
`endif
    model(a, b, c, s_eff, exp_s, exp_co, exp_ov);
    bus.op_a     = a;
    bus.op_b     = b;
    bus.cin      = c;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    acc_cyc      = cyc;
    bus.in_valid = 1'b0;
    chk("in_ready_after_accept", W'(bus.in_ready), W'(0));
  endtask

  // Wait for the result, check it, hold it for 'hold' cycles, then consume
  task automatic finish(input int hold);
    int t;
    t = 0;
    while (bus.out_valid !== 1'b1 && t < int'(4*NW + 10)) begin
      @(posedge clk); #1; t++;
    end
    chk("out_valid",  W'(bus.out_valid), W'(1));
    chk("latency",    W'(cyc - acc_cyc), W'(NW));
    chk("sum",        bus.sum, exp_s);
    chk("cout",       W'(bus.cout), W'(exp_co));
    chk("ovf",        W'(bus.ovf), W'(exp_ov));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_valid", W'(bus.out_valid), W'(1));
      chk("hold_ready", W'(bus.in_ready), W'(0));
      chk("hold_sum",   bus.sum, exp_s);
      chk("hold_cout",  W'(bus.cout), W'(exp_co));
      chk("hold_ovf",   W'(bus.ovf), W'(exp_ov));
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("valid_drop", W'(bus.out_valid), W'(0));
    chk("ready_back", W'(bus.in_ready), W'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int spur;
    bus.in_valid  = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.cin       = 1'b0;
`ifdef SUBTRACT_EN
    bus.op_sub    = 1'b0;
`endif
    bus.out_ready = 1'b0;

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_in_ready",  W'(bus.in_ready), W'(1));
    chk("rst_out_valid", W'(bus.out_valid), W'(0));
    chk("rst_sum",       bus.sum, '0);
    chk("rst_cout",      W'(bus.cout), W'(0));
    chk("rst_ovf",       W'(bus.ovf), W'(0));

    // Carry across the word-1/word-2 boundary
    start(64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
    finish(0);
    // Carry out of the top word
    start(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
    finish(0);
    // Signed overflow into the sign bit
    start(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
    finish(0);
    // Carry-in only
    start(64'hFFFF, 64'h0, 1'b1, 1'b0);
    finish(0);

`ifdef SUBTRACT_EN
    start(64'd5, 64'd7, 1'b0, 1'b1);
    finish(0);
    start(64'd7, 64'd5, 1'b1, 1'b1);
    finish(0);
`endif

    // Consumer back-pressure for 5 cycles
    start(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0);
    finish(5);

    // Reset while RUN is at word 2 aborts the operation
    start(64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_out_valid", W'(bus.out_valid), W'(0));
    chk("abort_sum",       bus.sum, '0);
    chk("abort_in_ready",  W'(bus.in_ready), W'(1));
    spur = 0;
    repeat (NW + 2) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) spur++;
    end
    chk("abort_no_result", W'(spur), W'(0));
    start(64'h1234, 64'h4321, 1'b0, 1'b0);
    finish(0);

    // New request while busy is ignored
    start(64'h0000_AAAA_0000_0001, 64'h0000_1111_0000_0002, 1'b0, 1'b0);
    @(posedge clk); #1;
    bus.op_a     = 64'hDEAD_BEEF_DEAD_BEEF;
    bus.op_b     = 64'hCAFE_F00D_CAFE_F00D;
    bus.cin      = 1'b1;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    finish(1);
    spur = 0;
    repeat (NW + 2) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) spur++;
    end
    chk("busy_req_dropped", W'(spur), W'(0));

    // Random operands
    for (int k = 0; k < 24; k++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = rand_op();
      rb = rand_op();
      if (k % 6 == 0) rb = ~ra;
      start(ra, rb, 1'(($urandom)), 1'(($urandom)));
      finish(int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mp_add_seq.md
MP_ADD_SEQ -- requirements
Module: mp_add_seq

Interface
REQ-001 SHALL have parameter NWORDS, default 4: number of 16-bit words per operand (legal range 2..8).
REQ-002 SHALL have localparam WORD_W, fixed at 16: width of the shared adder datapath.
REQ-003 SHALL use a single clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  request holds valid operands.
REQ-007 in_ready  output  1  block can accept a request.
REQ-008 op_a  input  16*NWORDS  operand A.
REQ-009 op_b  input  16*NWORDS  operand B.
REQ-010 cin  input  1  carry-in for the word-0 add.
REQ-011 op_sub  input  1  1 = A-B; exists only with SUBTRACT_EN.
REQ-012 out_valid  output  1  result is valid.
REQ-013 out_ready  input  1  consumer accepts the result.
REQ-014 sum  output  16*NWORDS  result.
REQ-015 cout  output  1  final carry-out; for subtraction, 1 = no borrow.
REQ-016 ovf  output  1  signed overflow of the full-width result.

Function
REQ-017 SHALL implement FSM states IDLE, RUN and DONE.
REQ-018 IDLE: in_ready=1; when in_valid=1, SHALL latch op_a, op_b and effective B, set idx=0, set carry=cin (or 1 when subtracting), and go to RUN.
REQ-019 RUN: each cycle SHALL add word[idx] of A and B_eff with the carry register through one adder, write sum word[idx], load carry from the adder Cout, and increment idx.
REQ-020 RUN: when idx=NWORDS-1, SHALL go to DONE.
REQ-021 Latency: out_valid SHALL rise exactly NWORDS cycles after the accepting edge.
REQ-022 DONE: SHALL hold out_valid=1 with sum/cout/ovf stable until out_ready=1, then go to IDLE on that edge.
REQ-023 in_ready SHALL be 0 in RUN and DONE: no overlap; peak throughput is one result per NWORDS+2 cycles.
REQ-024 ovf = (A_msb == B_eff_msb) && (sum_msb != A_msb), evaluated on the final word.
REQ-025 Carry SHALL propagate only through the carry register between words; there is no combinational path from word i to word i+1.
REQ-026 in_valid while in_ready=0 SHALL be ignored; operand changes during RUN SHALL NOT affect the result.

Reset
REQ-027 rst SHALL force IDLE, idx=0, carry=0, sum=0, cout=0, ovf=0, out_valid=0, in_ready=1 on the next edge.
REQ-028 rst in RUN or DONE SHALL abort the operation; no partial result is ever presented.
REQ-029 rst has priority over a simultaneous in_valid or out_ready.

Configuration
REQ-030 With macro SUBTRACT_EN defined, op_sub SHALL exist and select B_eff=~op_b with initial carry=1; cin is ignored when op_sub=1.
REQ-031 Without SUBTRACT_EN, op_sub SHALL be absent, B_eff=op_b, and the block is add-only.

Structure
REQ-032 Package mp_add_pkg SHALL hold WORD_W, the state enum type (IDLE/RUN/DONE) and the idx width function.
REQ-033 SHALL instantiate exactly one existing manchester_adder (A, B, Cin, Sum, Cout) as the shared datapath; no other sub-module.

Verification
REQ-034 A=0x00000000FFFFFFFF, B=0x1, cin=0 -> sum=0x0000000100000000, cout=0, ovf=0, out_valid 4 cycles after accept.
REQ-035 A=0xFFFFFFFFFFFFFFFF, B=0x1, cin=0 -> sum=0x0, cout=1, ovf=0; A=0x7FFFFFFFFFFFFFFF, B=0x1 -> sum=0x8000000000000000, ovf=1.
REQ-036 SUBTRACT_EN, A=5, B=7, op_sub=1 -> sum=0xFFFFFFFFFFFFFFFE, cout=0; A=7, B=5 -> sum=2, cout=1.
REQ-037 out_ready held 0 for 5 cycles in DONE -> sum/cout/ovf stable and in_ready=0 throughout; on out_ready=1, in_ready=1 the next cycle.
REQ-038 rst pulsed at RUN idx=2 -> next cycle IDLE, out_valid=0, sum=0; a following request of 0x1234+0x4321 -> sum=0x5555.
REQ-039 in_valid pulsed during RUN with different operands -> ignored; the original result is returned unchanged.
